video_io_regs: RTL and testbench

- Parametrised ISA-side register and bus-interface block for the CGA/Tandy video path.
- Owns three things:
  - Register I/O decode.
  - Mode/colour registers and an indexed Tandy register file with a PAL_DEPTH-entry palette.
  - An ISA wait-state generator.
- Sits between the ISA bus and the CRTC/sequencer/pixel pipeline. Replaces the ad-hoc register logic at video top level.
- New behaviour:
  - Exactly-once write per strobe.
  - Indexed palette with optional auto-increment.
  - Bounded wait-state FSM.

---
 rtl/video_pkg.sv | 20 ++
 rtl/isa_wait_gen.sv | 68 ++++++
 rtl/video_io_regs.sv | 164 ++++++++++++++++
 tb/tb_video_io_regs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared register offsets, Tandy index map and wait-state FSM encoding for the video I/O block.
package video_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_COLOR  = 4'h9;
  localparam logic [3:0] OFS_STATUS = 4'hA;
  localparam logic [3:0] OFS_DATA   = 4'hE;

  localparam logic [4:0] IDX_BORDER = 5'h02;
  localparam logic [4:0] IDX_MODE   = 5'h03;
  localparam logic [4:0] IDX_PAL    = 5'h10;

  typedef enum logic [1:0] {
    WS_IDLE   = 2'd0,
    WS_WAIT_A = 2'd1,
    WS_WAIT_B = 2'd2,
    WS_READY  = 2'd3
  } wait_state_e;

endpackage

// File: rtl/isa_wait_gen.sv
// ISA memory wait-state generator: pulls ready low from the edge an access is seen until the
// sequencer passes the start/end phases, or a cycle timeout expires; drops out when the access ends.
module isa_wait_gen
  import video_pkg::*;
#(
  parameter logic [4:0] WAIT_START = 5'd17,
  parameter logic [4:0] WAIT_END   = 5'd20,
  parameter logic [7:0] WAIT_MAX   = 8'd64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_acc,
  input  logic [4:0] i_clk_seq,
  output logic       o_bus_rdy
);

  wait_state_e r_state;
  wait_state_e w_state_nxt;
  logic [7:0]  r_cnt;
  logic        w_timeout;
  logic        w_bus_rdy;

  // The edge that takes the count to WAIT_MAX is the edge that enters READY.
  assign w_timeout = (r_cnt == (WAIT_MAX - 8'd1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= WS_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WS_IDLE) begin
        r_cnt <= 8'd0;
      end else if ((r_state == WS_WAIT_A) || (r_state == WS_WAIT_B)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus_rdy   = 1'b1;
    case (r_state)
      WS_IDLE: begin
        if (i_acc) w_state_nxt = WS_WAIT_A;
      end
      WS_WAIT_A: begin
        w_bus_rdy = 1'b0;
        if (!i_acc)                       w_state_nxt = WS_IDLE;
        else if (w_timeout)               w_state_nxt = WS_READY;
        else if (i_clk_seq == WAIT_START) w_state_nxt = WS_WAIT_B;
      end
      WS_WAIT_B: begin
        w_bus_rdy = 1'b0;
        if (!i_acc)                     w_state_nxt = WS_IDLE;
        else if (w_timeout)             w_state_nxt = WS_READY;
        else if (i_clk_seq == WAIT_END) w_state_nxt = WS_READY;
      end
      WS_READY: begin
        if (!i_acc) w_state_nxt = WS_IDLE;
      end
      default: w_state_nxt = WS_IDLE;
    endcase
  end

  assign o_bus_rdy = w_bus_rdy;

endmodule

// File: rtl/video_io_regs.sv
// ISA register block for the CGA/Tandy video path: I/O decode, mode/colour/Tandy/palette registers
// and optional memory wait states. A write strobe lands exactly once, 3 clks after iow_l falls.
module video_io_regs
  import video_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
  parameter int unsigned PAL_DEPTH    = 16,
  parameter bit          AUTO_INC     = 1'b0,
  parameter bit          USE_BUS_WAIT = 1'b0,
  parameter logic [4:0]  WAIT_START   = 5'd17,
  parameter logic [4:0]  WAIT_END     = 5'd20,
  parameter logic [7:0]  WAIT_MAX     = 8'd64,
  parameter logic [7:0]  CTRL_RESET   = 8'h29
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            bus_a,
  input  logic [7:0]             bus_d,
  input  logic                   bus_ior_l,
  input  logic                   bus_iow_l,
  input  logic                   bus_memr_l,
  input  logic                   bus_memw_l,
  input  logic                   bus_aen,
  input  logic                   mem_cs,
  input  logic [4:0]             clk_seq,
  input  logic                   vsync_l,
  input  logic                   display_enable,
  input  logic [7:0]             crtc_rd_data,
  output logic                   crtc_cs,
  output logic [7:0]             bus_out,
  output logic                   bus_dir,
  output logic                   bus_rdy,
  output logic [7:0]             ctrl_reg,
  output logic [7:0]             color_reg,
  output logic [3:0]             border_color,
  output logic [7:0]             tandy_mode,
  output logic [4*PAL_DEPTH-1:0] palette_flat,
  output logic                   palette_wr
);

  logic       r_iow_s1, r_iow_s2, r_iow_s3;
  logic       r_vs_s1, r_vs_s2, r_de_s1, r_de_s2;
  logic [7:0] r_ctrl, r_color, r_mode;
  logic [3:0] r_border;
  logic [4:0] r_index;
  logic       r_pal_wr;
  logic [3:0] r_pal [PAL_DEPTH];

  logic       w_io_hit, w_crtc_cs, w_status_hit;
  logic [3:0] w_ofs;
  logic       w_wr_pulse, w_wr_ctrl, w_wr_color, w_wr_index, w_wr_data, w_wr_pal;
  logic       w_pal_hit, w_pal_last;
  logic       w_acc;

  assign w_ofs        = bus_a[3:0];
  assign w_io_hit     = ~bus_aen & (bus_a[15:4] == IO_BASE_ADDR[15:4]);
  assign w_crtc_cs    = ~bus_aen & (bus_a[15:3] == IO_BASE_ADDR[15:3]);
  assign w_status_hit = w_io_hit & (w_ofs == OFS_STATUS);

  // Falling edge of the synchronised strobe gives one pulse however long iow_l is held.
  assign w_wr_pulse = r_iow_s3 & ~r_iow_s2;
  assign w_wr_ctrl  = w_wr_pulse & w_io_hit & (w_ofs == OFS_CTRL);
  assign w_wr_color = w_wr_pulse & w_io_hit & (w_ofs == OFS_COLOR);
  assign w_wr_index = w_wr_pulse & w_io_hit & (w_ofs == OFS_STATUS);
  assign w_wr_data  = w_wr_pulse & w_io_hit & (w_ofs == OFS_DATA);

  assign w_pal_hit  = r_index[4] & ({1'b0, r_index[3:0]} < 5'(PAL_DEPTH));
  assign w_pal_last = (r_index[3:0] == 4'(PAL_DEPTH - 1));
  assign w_wr_pal   = w_wr_data & w_pal_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iow_s1 <= 1'b1;
      r_iow_s2 <= 1'b1;
      r_iow_s3 <= 1'b1;
      r_vs_s1  <= 1'b1;
      r_vs_s2  <= 1'b1;
      r_de_s1  <= 1'b0;
      r_de_s2  <= 1'b0;
    end else begin
      r_iow_s1 <= bus_iow_l;
      r_iow_s2 <= r_iow_s1;
      r_iow_s3 <= r_iow_s2;
      r_vs_s1  <= vsync_l;
      r_vs_s2  <= r_vs_s1;
      r_de_s1  <= display_enable;
      r_de_s2  <= r_de_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= CTRL_RESET;
      r_color  <= 8'h00;
      r_border <= 4'h0;
      r_mode   <= 8'h00;
      r_index  <= 5'h00;
      r_pal_wr <= 1'b0;
    end else begin
      r_pal_wr <= w_wr_pal;
      if (w_wr_ctrl)  r_ctrl  <= bus_d;
      if (w_wr_color) r_color <= bus_d;
      if (w_wr_index) begin
        r_index <= bus_d[4:0];
      end else if (w_wr_pal && AUTO_INC) begin
        r_index <= w_pal_last ? IDX_PAL : (r_index + 5'd1);
      end
      if (w_wr_data && (r_index == IDX_BORDER)) r_border <= bus_d[3:0];
      if (w_wr_data && (r_index == IDX_MODE))   r_mode   <= bus_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++) r_pal[i] <= 4'(i);
    end else begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
        if (w_wr_pal && (r_index[3:0] == 4'(i))) r_pal[i] <= bus_d[3:0];
      end
    end
  end

  for (genvar gi = 0; gi < PAL_DEPTH; gi++) begin : g_pal
    assign palette_flat[4*gi +: 4] = r_pal[gi];
  end

  always_comb begin
    bus_out = 8'h00;
    if (w_status_hit) begin
      bus_out = {4'hF, r_vs_s2, 2'b10, ~r_de_s2};
    end else if (w_crtc_cs && bus_a[0]) begin
      bus_out = crtc_rd_data;
    end
  end

  assign bus_dir = (w_crtc_cs | w_status_hit) & ~bus_ior_l;
  assign w_acc   = mem_cs & (~bus_memr_l | ~bus_memw_l);

  if (USE_BUS_WAIT) begin : g_wait
    isa_wait_gen #(
      .WAIT_START(WAIT_START),
      .WAIT_END  (WAIT_END),
      .WAIT_MAX  (WAIT_MAX)
    ) u_wait (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_acc    (w_acc),
      .i_clk_seq(clk_seq),
      .o_bus_rdy(bus_rdy)
    );
  end else begin : g_no_wait
    logic w_unused_wait;
    assign w_unused_wait = ^{w_acc, clk_seq};
    assign bus_rdy       = 1'b1;
  end

  assign crtc_cs      = w_crtc_cs;
  assign ctrl_reg     = r_ctrl;
  assign color_reg    = r_color;
  assign border_color = r_border;
  assign tandy_mode   = r_mode;
  assign palette_wr   = r_pal_wr;

endmodule

// File: tb/tb_video_io_regs.sv
// Bench for video_io_regs: register writes scored through an event queue, table-driven reads,
// and hand-written sequences for the wait-state FSM and asynchronous reset.
module tb_video_io_regs;

  localparam logic [2:0] K_NONE = 3'd0, K_CTRL = 3'd1, K_COLOR = 3'd2,
                         K_BORDER = 3'd3, K_MODE = 3'd4, K_PAL = 3'd5;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] idx;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    bit          rd;
    bit          aen;
    logic [15:0] a;
    logic [7:0]  d;
    logic [2:0]  kind;
    logic [3:0]  idx;
    logic [7:0]  exp;
    bit          dir;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen, mem_cs;
  logic [4:0]  clk_seq;
  logic        vsync_l, display_enable;
  logic [7:0]  crtc_rd_data;
  logic        crtc_cs, bus_dir, bus_rdy, palette_wr;
  logic [7:0]  bus_out, ctrl_reg, color_reg, tandy_mode;
  logic [3:0]  border_color;
  logic [63:0] palette_flat;

  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  ev_t  sb_q[$];
  vec_t tbl[17];
  logic [7:0] p_ctrl, p_color, p_mode;
  logic [3:0] p_border;

  video_io_regs #(
    .PAL_DEPTH   (16),
    .AUTO_INC    (1'b1),
    .USE_BUS_WAIT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
    .bus_memw_l(bus_memw_l), .bus_aen(bus_aen), .mem_cs(mem_cs), .clk_seq(clk_seq),
    .vsync_l(vsync_l), .display_enable(display_enable), .crtc_rd_data(crtc_rd_data),
    .crtc_cs(crtc_cs), .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
    .ctrl_reg(ctrl_reg), .color_reg(color_reg), .border_color(border_color),
    .tandy_mode(tandy_mode), .palette_flat(palette_flat), .palette_wr(palette_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sb_match(input logic [2:0] kind, input logic [7:0] val);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected: kind %0d value %0h, expected no event", kind, val);
      return;
    end
    e = sb_q.pop_front();
    chk("sb_kind", 64'(kind), 64'(e.kind));
    if (kind == K_PAL) chk("sb_pal", 64'(palette_flat[4*e.idx +: 4]), 64'(e.val[3:0]));
    else               chk("sb_val", 64'(val), 64'(e.val));
  endtask

  // Every observed register change or palette pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctrl_reg !== p_ctrl)       sb_match(K_CTRL, ctrl_reg);
      if (color_reg !== p_color)     sb_match(K_COLOR, color_reg);
      if (border_color !== p_border) sb_match(K_BORDER, {4'h0, border_color});
      if (tandy_mode !== p_mode)     sb_match(K_MODE, tandy_mode);
      if (palette_wr)                sb_match(K_PAL, 8'h00);
    end
    p_ctrl   <= ctrl_reg;
    p_color  <= color_reg;
    p_border <= border_color;
    p_mode   <= tandy_mode;
  end

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input bit aen,
                       input logic [2:0] kind, input logic [3:0] idx, input logic [7:0] val);
    ev_t e;
    if (kind != K_NONE) begin
      e.kind = kind; e.idx = idx; e.val = val;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
    repeat (6) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (4) @(negedge clk);
    bus_aen = 1'b0;
  endtask

  task automatic cnt_low(input int limit, output int lowc);
    lowc = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus_rdy) break;
      lowc++;
      if (clk_seq != 5'd0 || lowc > 1000) clk_seq = clk_seq + 5'd1;
    end
  endtask

  initial begin
    int lat;
    int lowc;
    ev_t e;
    reset = 1'b1; bus_a = 16'h03DA; bus_d = 8'h00; bus_ior_l = 1'b0; bus_iow_l = 1'b1;
    bus_memr_l = 1'b1; bus_memw_l = 1'b1; bus_aen = 1'b0; mem_cs = 1'b0; clk_seq = 5'd0;
    vsync_l = 1'b1; display_enable = 1'b0; crtc_rd_data = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'(ctrl_reg), 64'h29);
    chk("rst_color", 64'(color_reg), 64'h00);
    chk("rst_border", 64'(border_color), 64'h0);
    chk("rst_mode", 64'(tandy_mode), 64'h00);
    chk("rst_palette", palette_flat, 64'hFEDCBA9876543210);
    chk("rst_palwr", 64'(palette_wr), 64'd0);
    chk("rst_rdy", 64'(bus_rdy), 64'd1);
    chk("rst_status", 64'(bus_out), 64'hFD);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Status through the synchronisers: two clocks to settle.
    vsync_l = 1'b0; display_enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("status_f4", 64'(bus_out), 64'hF4);
    chk("status_dir", 64'(bus_dir), 64'd1);
    bus_ior_l = 1'b1; vsync_l = 1'b1; display_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Long strobe at base+8: one load, landing on the third sample after the fall.
    e.kind = K_CTRL; e.idx = 4'd0; e.val = 8'h1A;
    sb_q.push_back(e);
    bus_a = 16'h03D8; bus_d = 8'h1A; bus_iow_l = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (ctrl_reg == 8'h1A) break;
    end
    chk("ctrl_latency", 64'(lat), 64'd3);
    repeat (20 - lat) @(negedge clk);
    bus_iow_l = 1'b1;
    repeat (4) @(negedge clk);

    tbl[0]  = '{0, 0, 16'h03D9, 8'h3C, K_COLOR,  4'd0, 8'h3C, 1'b0};
    tbl[1]  = '{0, 0, 16'h03DA, 8'h02, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[2]  = '{0, 0, 16'h03DE, 8'hF7, K_BORDER, 4'd0, 8'h07, 1'b0};
    tbl[3]  = '{0, 0, 16'h03DA, 8'h03, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[4]  = '{0, 0, 16'h03DE, 8'hA5, K_MODE,   4'd0, 8'hA5, 1'b0};
    tbl[5]  = '{0, 0, 16'h03DA, 8'h12, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[6]  = '{0, 0, 16'h03DE, 8'h0B, K_PAL,    4'd2, 8'h0B, 1'b0};
    tbl[7]  = '{0, 0, 16'h03DE, 8'h0C, K_PAL,    4'd3, 8'h0C, 1'b0};
    tbl[8]  = '{0, 0, 16'h03DA, 8'h07, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[9]  = '{0, 0, 16'h03DE, 8'hFF, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[10] = '{0, 1, 16'h03D9, 8'h77, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[11] = '{0, 0, 16'h03B8, 8'h55, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[12] = '{1, 0, 16'h03DA, 8'h00, K_NONE,   4'd0, 8'hFD, 1'b1};
    tbl[13] = '{1, 0, 16'h03D5, 8'h00, K_NONE,   4'd0, 8'h5A, 1'b1};
    tbl[14] = '{1, 0, 16'h03D4, 8'h00, K_NONE,   4'd0, 8'h00, 1'b1};
    tbl[15] = '{1, 0, 16'h03D8, 8'h00, K_NONE,   4'd0, 8'h00, 1'b0};
    tbl[16] = '{1, 1, 16'h03DA, 8'h00, K_NONE,   4'd0, 8'h00, 1'b0};
    for (int i = 0; i < 17; i++) begin
      if (!tbl[i].rd) begin
        io_wr(tbl[i].a, tbl[i].d, tbl[i].aen, tbl[i].kind, tbl[i].idx, tbl[i].exp);
      end else begin
        @(negedge clk);
        bus_a = tbl[i].a; bus_aen = tbl[i].aen; bus_ior_l = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("rd_data[%0d]", i), 64'(bus_out), 64'(tbl[i].exp));
        chk($sformatf("rd_dir[%0d]", i), 64'(bus_dir), 64'(tbl[i].dir));
        bus_ior_l = 1'b1; bus_aen = 1'b0;
      end
    end
    chk("hold_ctrl", 64'(ctrl_reg), 64'h1A);
    chk("hold_color", 64'(color_reg), 64'h3C);
    chk("hold_border", 64'(border_color), 64'h7);
    chk("hold_mode", 64'(tandy_mode), 64'hA5);
    chk("pal_after_tbl", palette_flat, 64'hFEDCBA987654CB10);

    // Auto-increment across the top of the palette wraps to entry 0, then on to entry 1.
    io_wr(16'h03DA, 8'h1F, 1'b0, K_NONE, 4'd0, 8'h00);
    io_wr(16'h03DE, 8'h05, 1'b0, K_PAL, 4'd15, 8'h05);
    io_wr(16'h03DE, 8'h09, 1'b0, K_PAL, 4'd0, 8'h09);
    io_wr(16'h03DE, 8'h03, 1'b0, K_PAL, 4'd1, 8'h03);
    chk("pal_wrap", palette_flat, 64'h5EDCBA987654CB39);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Wait window: access seen at phase 3, ready returns on the edge where phase 20 is seen.
    @(negedge clk);
    clk_seq = 5'd3; mem_cs = 1'b1; bus_memr_l = 1'b0;
    cnt_low(100, lowc);
    chk("wait_window_cycles", 64'(lowc), 64'd17);
    repeat (3) @(negedge clk);
    chk("ready_hold", 64'(bus_rdy), 64'd1);
    bus_memr_l = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 64'(bus_rdy), 64'd1);
    bus_memr_l = 1'b0;
    @(negedge clk);
    chk("reaccess_waits", 64'(bus_rdy), 64'd0);
    bus_memr_l = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(bus_rdy), 64'd1);

    // Frozen sequencer: only the timeout releases ready.
    clk_seq = 5'd0; bus_memw_l = 1'b0;
    cnt_low(200, lowc);
    chk("timeout_cycles", 64'(lowc), 64'd64);
    bus_memw_l = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a wait releases ready without a clock edge.
    bus_memw_l = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_wait_low", 64'(bus_rdy), 64'd0);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_rdy", 64'(bus_rdy), 64'd1);
    chk("async_rst_ctrl", 64'(ctrl_reg), 64'h29);
    bus_memw_l = 1'b1; mem_cs = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
